jt900h_busarb: RTL and testbench

Memory bus arbiter and sequencer for the JT900H core. It shares the single 16-bit external memory bus between the opcode prefetch path and the data load/store path driven by the control unit. It grants one requester at a time and splits 1/2/4-byte data accesses at any alignment into 16-bit bus beats. It reassembles read data right-justified and returns a single completion pulse.

---
 rtl/jt900h_busarb.sv | 224 ++++++++++++++++++++++
 tb/tb_jt900h_busarb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_busarb.sv
// jt900h_busarb
// Memory bus arbiter and sequencer for the JT900H core.
// It shares one 16-bit external bus between the opcode prefetch path and the
// data load/store path. Data accesses of 1, 2 or 4 bytes at any alignment are
// split into 16-bit beats. Read data is returned right-justified.
//
// Ports:
//   clk, rst, cen     clock, async active-high reset, clock enable
//   fetch_*           opcode word read: level request, ok pulse, data word
//   data_rd/wr/addr   data access request (level) with byte address
//   data_len/din      one-hot size (001/010/100) and right-justified write data
//   data_dout/ok      right-justified read data and completion pulse
//   bus_*             external bus: cs, we, word address, active-low lanes,
//                     write data, read data and beat acknowledge
module jt900h_busarb (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  output logic        fetch_ok,
  output logic [15:0] fetch_data,
  input  logic        data_rd,
  input  logic        data_wr,
  input  logic [23:0] data_addr,
  input  logic [2:0]  data_len,
  input  logic [31:0] data_din,
  output logic [31:0] data_dout,
  output logic        data_ok,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [23:0] bus_addr,
  output logic [1:0]  bus_dsn,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  input  logic        bus_ok
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  state_t      state, state_nx;
  logic        last_data, last_data_nx;
  logic        odd, odd_nx;
  logic [2:0]  nbytes, nbytes_nx;
  logic [2:0]  pos, pos_nx;
  logic [31:0] wsh, wsh_nx;
  logic [31:0] acc, acc_nx;

  logic        fetch_ok_nx, data_ok_nx;
  logic [15:0] fetch_data_nx;
  logic [31:0] data_dout_nx;
  logic        cs_nx, we_nx;
  logic [23:0] addr_nx;
  logic [1:0]  dsn_nx;
  logic [15:0] dout_nx;

  logic        data_req, grant_data;
  logic [2:0]  grant_n;
  logic        first_odd, one_left, single;
  logic [2:0]  pos_step;
  logic [31:0] wsh_step;
  logic [31:0] rd_lanes;
  logic        unused_bits;

  // Address bit 0 of a fetch is ignored and len[0] adds nothing beyond the
  // "byte" default, so these bits are deliberately left unused.
  assign unused_bits = fetch_addr[0] ^ data_len[0];

  // Lane strobes for a beat that starts at byte offset p of an n-byte access.
  function automatic logic [1:0] lane_dsn(input logic [2:0] p, input logic o,
                                          input logic [2:0] n);
    logic [2:0] rem;
    rem = n - p;
    if (p == 3'd0 && o) return 2'b01;
    if (rem == 3'd1)    return 2'b10;
    return 2'b00;
  endfunction

  // Write beat data; w holds the not-yet-sent bytes right-justified.
  function automatic logic [15:0] lane_dout(input logic [15:0] w, input logic [2:0] p,
                                            input logic o, input logic [2:0] n);
    logic [2:0] rem;
    rem = n - p;
    if (p == 3'd0 && o) return {w[7:0], 8'h00};
    if (rem == 3'd1)    return {8'h00, w[7:0]};
    return w;
  endfunction

  // Arbitration: data normally wins, but right after a data transaction a
  // waiting fetch gets the bus so prefetch can never be starved.
  assign data_req   = data_rd | data_wr;
  assign grant_data = data_req & ~(last_data & fetch_req);
  assign grant_n    = data_len[2] ? 3'd4 : (data_len[1] ? 3'd2 : 3'd1);

  // Per-beat bookkeeping: pos counts bytes already transferred. A beat moves a
  // single byte when it is the odd first beat or only one byte remains.
  assign first_odd = (pos == 3'd0) & odd;
  assign one_left  = (nbytes - pos) == 3'd1;
  assign single    = first_odd | one_left;
  assign pos_step  = pos + (single ? 3'd1 : 3'd2);
  assign wsh_step  = single ? {8'h00, wsh[31:8]} : {16'h0000, wsh[31:16]};
  assign rd_lanes  = first_odd ? {24'h0, bus_din[15:8]} :
                     one_left  ? ({24'h0, bus_din[7:0]} << {pos, 3'b000}) :
                                 ({16'h0, bus_din} << {pos, 3'b000});

  // Next-state and next-output logic. Every output is registered, so this
  // block computes the value each register takes on the next cen edge.
  always_comb begin
    state_nx      = state;
    last_data_nx  = last_data;
    odd_nx        = odd;
    nbytes_nx     = nbytes;
    pos_nx        = pos;
    wsh_nx        = wsh;
    acc_nx        = acc;
    fetch_ok_nx   = 1'b0;
    data_ok_nx    = 1'b0;
    fetch_data_nx = fetch_data;
    data_dout_nx  = data_dout;
    cs_nx         = bus_cs;
    we_nx         = bus_we;
    addr_nx       = bus_addr;
    dsn_nx        = bus_dsn;
    dout_nx       = bus_dout;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_nx  = DATA;
          odd_nx    = data_addr[0];
          nbytes_nx = grant_n;
          pos_nx    = 3'd0;
          wsh_nx    = data_din;
          acc_nx    = 32'h0;
          cs_nx     = 1'b1;
          we_nx     = ~data_rd;
          addr_nx   = {data_addr[23:1], 1'b0};
          dsn_nx    = lane_dsn(3'd0, data_addr[0], grant_n);
          dout_nx   = data_rd ? 16'h0 : lane_dout(data_din[15:0], 3'd0, data_addr[0], grant_n);
        end else if (fetch_req) begin
          state_nx = FETCH;
          cs_nx    = 1'b1;
          we_nx    = 1'b0;
          addr_nx  = {fetch_addr[23:1], 1'b0};
          dsn_nx   = 2'b00;
          dout_nx  = 16'h0;
        end
      end
      FETCH: begin
        if (bus_ok) begin
          state_nx      = DONE;
          fetch_data_nx = bus_din;
          fetch_ok_nx   = 1'b1;
          last_data_nx  = 1'b0;
          cs_nx         = 1'b0;
          dsn_nx        = 2'b11;
        end
      end
      DATA: begin
        if (bus_ok) begin
          pos_nx = pos_step;
          wsh_nx = wsh_step;
          acc_nx = acc | rd_lanes;
          if (pos_step >= nbytes) begin
            state_nx     = DONE;
            data_ok_nx   = 1'b1;
            last_data_nx = 1'b1;
            cs_nx        = 1'b0;
            we_nx        = 1'b0;
            dsn_nx       = 2'b11;
            dout_nx      = 16'h0;
            if (!bus_we) data_dout_nx = acc | rd_lanes;
          end else begin
            addr_nx = {bus_addr[23:1] + 23'd1, 1'b0};
            dsn_nx  = lane_dsn(pos_step, odd, nbytes);
            dout_nx = bus_we ? lane_dout(wsh_step[15:0], pos_step, odd, nbytes) : 16'h0;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers. Reset aborts any beat in flight and discards
  // partially assembled read data; cen low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_data  <= 1'b0;
      odd        <= 1'b0;
      nbytes     <= 3'd1;
      pos        <= 3'd0;
      wsh        <= 32'h0;
      acc        <= 32'h0;
      fetch_ok   <= 1'b0;
      data_ok    <= 1'b0;
      fetch_data <= 16'h0;
      data_dout  <= 32'h0;
      bus_cs     <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 24'h0;
      bus_dsn    <= 2'b11;
      bus_dout   <= 16'h0;
    end else if (cen) begin
      state      <= state_nx;
      last_data  <= last_data_nx;
      odd        <= odd_nx;
      nbytes     <= nbytes_nx;
      pos        <= pos_nx;
      wsh        <= wsh_nx;
      acc        <= acc_nx;
      fetch_ok   <= fetch_ok_nx;
      data_ok    <= data_ok_nx;
      fetch_data <= fetch_data_nx;
      data_dout  <= data_dout_nx;
      bus_cs     <= cs_nx;
      bus_we     <= we_nx;
      bus_addr   <= addr_nx;
      bus_dsn    <= dsn_nx;
      bus_dout   <= dout_nx;
    end
  end

endmodule

// File: tb/tb_jt900h_busarb.sv
// tb_jt900h_busarb
// Self-checking bench for jt900h_busarb. A bus responder answers beats from a
// sparse memory model with programmable wait states and logs every accepted
// beat. Expected beats and read data come from a byte-by-byte model: byte A+i
// lives in word (A+i)&~1, lane (A+i)&1.
module tb_jt900h_busarb;

  logic        clk, rst, cen;
  logic        fetch_req, fetch_ok;
  logic [23:0] fetch_addr;
  logic [15:0] fetch_data;
  logic        data_rd, data_wr, data_ok;
  logic [23:0] data_addr;
  logic [2:0]  data_len;
  logic [31:0] data_din, data_dout;
  logic        bus_cs, bus_we, bus_ok;
  logic [23:0] bus_addr;
  logic [1:0]  bus_dsn;
  logic [15:0] bus_dout, bus_din;

  jt900h_busarb dut (
    .clk(clk), .rst(rst), .cen(cen),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ok(fetch_ok), .fetch_data(fetch_data),
    .data_rd(data_rd), .data_wr(data_wr), .data_addr(data_addr), .data_len(data_len),
    .data_din(data_din), .data_dout(data_dout), .data_ok(data_ok),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dsn(bus_dsn),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ok(bus_ok)
  );

  localparam logic [93:0] RST_VAL = {1'b0, 1'b0, 24'h0, 2'b11, 16'h0, 1'b0, 16'h0, 1'b0, 32'h0};

  int          total = 0;
  int          bad   = 0;
  int          wait_states = 0;
  int          wait_cnt = 0;
  int          stab_err = 0;
  int          viol = 0;
  int          dok_cnt = 0;
  int          fok_cnt = 0;
  logic [15:0] mem [logic [23:0]];
  logic [42:0] log_q [$];
  logic [42:0] exp_q [$];
  logic [31:0] exp_rd;
  logic [7:0]  order_q [$];
  logic [42:0] held;

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus word contents: explicit entries or an address-derived pattern.
  function automatic logic [15:0] mem_rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5AC3 ^ {a[23:16], a[23:16]};
  endfunction

  // Byte-level model of one data access: builds expected beats
  // {we, dsn, addr, dout} and the right-justified read result.
  task automatic build_exp(input logic [23:0] a, input int n, input logic we,
                           input logic [31:0] din);
    logic [23:0] b, w;
    logic [42:0] t;
    logic [15:0] m;
    exp_q.delete();
    exp_rd = 32'h0;
    for (int i = 0; i < n; i++) begin
      b = a + 24'(i);
      w = {b[23:1], 1'b0};
      if (exp_q.size() == 0) exp_q.push_back({we, 2'b11, w, 16'h0});
      else begin
        t = exp_q[exp_q.size()-1];
        if (t[39:16] != w) exp_q.push_back({we, 2'b11, w, 16'h0});
      end
      t = exp_q[exp_q.size()-1];
      if (b[0]) t[41] = 1'b0; else t[40] = 1'b0;
      if (we) begin
        if (b[0]) t[15:8] = din[8*i +: 8]; else t[7:0] = din[8*i +: 8];
      end
      exp_q[exp_q.size()-1] = t;
      m = mem_rd(w);
      exp_rd[8*i +: 8] = b[0] ? m[15:8] : m[7:0];
    end
  endtask

  // Bus responder: acknowledges each beat after wait_states idle cycles, logs
  // the accepted beat and checks it stays frozen while waiting. bus_ok is
  // randomised while no beat is active since the arbiter must ignore it.
  always @(negedge clk) begin
    if (rst) begin
      wait_cnt = 0;
      bus_ok   = 1'b0;
    end else if (!bus_cs) begin
      wait_cnt = 0;
      bus_ok   = 1'($urandom_range(0, 1));
      bus_din  = 16'($urandom);
    end else if (cen) begin
      if (wait_cnt == 0) held = {bus_we, bus_dsn, bus_addr, bus_we ? bus_dout : 16'h0};
      else if (held !== {bus_we, bus_dsn, bus_addr, bus_we ? bus_dout : 16'h0}) stab_err++;
      if (wait_cnt >= wait_states) begin
        bus_ok  = 1'b1;
        bus_din = mem_rd(bus_addr);
        log_q.push_back(held);
        wait_cnt = 0;
      end else begin
        bus_ok  = 1'b0;
        bus_din = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      bus_ok = 1'b0;
    end
  end

  // Completion monitor: counts ok pulses (one per enabled cycle), records the
  // completion order and flags pulses that overlap each other or a beat.
  always @(negedge clk) begin
    if (!rst && cen) begin
      if (data_ok)  begin dok_cnt++; order_q.push_back("D"); end
      if (fetch_ok) begin fok_cnt++; order_q.push_back("F"); end
      if ((data_ok && fetch_ok) || ((data_ok || fetch_ok) && bus_cs)) viol++;
    end
  end

  // Drive one data access and wait (bounded) for its completion. Address,
  // size and write data are scrambled after grant to confirm they are latched.
  task automatic run_data(input logic [23:0] a, input logic [2:0] len, input logic rd,
                          input logic wr, input logic [31:0] din, output bit got);
    int d0;
    d0 = dok_cnt;
    log_q.delete();
    got = 0;
    data_addr = a; data_len = len; data_din = din;
    data_rd = rd; data_wr = wr;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        data_addr = 24'($urandom); data_len = 3'($urandom); data_din = $urandom;
      end
      if (dok_cnt != d0) got = 1;
    end
    data_rd = 1'b0; data_wr = 1'b0;
  endtask

  task automatic run_fetch(input logic [23:0] fa, output bit got);
    int f0;
    f0 = fok_cnt;
    log_q.delete();
    got = 0;
    fetch_addr = fa;
    fetch_req  = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 0) fetch_addr = 24'($urandom);
      if (fok_cnt != f0) got = 1;
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; cen = 1'b1;
    fetch_req = 0; fetch_addr = 0; data_rd = 0; data_wr = 0;
    data_addr = 0; data_len = 0; data_din = 0; bus_din = 0; bus_ok = 0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus_cs, bus_we, bus_addr, bus_dsn, bus_dout, fetch_ok, fetch_data, data_ok, data_dout} !== RST_VAL) begin
      bad++;
      $display("[TB] FAIL reset_values got %h exp %h",
               {bus_cs, bus_we, bus_addr, bus_dsn, bus_dout, fetch_ok, fetch_data, data_ok, data_dout}, RST_VAL);
    end
  endtask

  // Both requesters held high out of reset: data first, then alternation.
  task automatic test_contention;
    fetch_addr = 24'h000020; fetch_req = 1'b1;
    data_addr = 24'h000010; data_len = 3'b010; data_rd = 1'b1;
    log_q.delete(); order_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 100 && order_q.size() < 3; c++) begin
      @(posedge clk); #1;
    end
    fetch_req = 1'b0; data_rd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (order_q.size() < 3 || log_q.size() < 3) begin
      bad++;
      $display("[TB] FAIL contention_count got %0d completions exp 3", order_q.size());
    end else begin
      total++;
      if ({order_q[0], order_q[1], order_q[2]} !== "DFD") begin
        bad++;
        $display("[TB] FAIL contention_order got %s exp DFD", {order_q[0], order_q[1], order_q[2]});
      end
      total++;
      if ({log_q[0][39:16], log_q[1][39:16], log_q[2][39:16]} !== {24'h10, 24'h20, 24'h10}) begin
        bad++;
        $display("[TB] FAIL contention_addrs got %h exp %h",
                 {log_q[0][39:16], log_q[1][39:16], log_q[2][39:16]}, {24'h10, 24'h20, 24'h10});
      end
    end
    total++;
    if (viol !== 0) begin bad++; $display("[TB] FAIL contention_overlap got %0d exp 0", viol); end
  endtask

  task automatic test_fetch;
    bit got;
    mem[24'h001234] = 16'hBEEF;
    wait_states = 0;
    run_fetch(24'h001235, got);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL fetch_timeout got 0 exp 1"); end
    total++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 2'b00, 24'h001234, 16'h0}) begin
      bad++;
      $display("[TB] FAIL fetch_beat got %0d beats exp 1 beat %h", log_q.size(), {1'b0, 2'b00, 24'h001234, 16'h0});
    end
    total++;
    if (fetch_data !== 16'hBEEF) begin bad++; $display("[TB] FAIL fetch_data got %h exp beef", fetch_data); end
  endtask

  // cen low during DONE must hold the ok pulse until the next enabled edge.
  task automatic test_cen;
    int held_ok;
    mem[24'h000400] = 16'h1357;
    wait_states = 0;
    held_ok = 0;
    fetch_addr = 24'h000401; fetch_req = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_cs !== 1'b1) begin bad++; $display("[TB] FAIL cen_grant got %b exp 1", bus_cs); end
    @(posedge clk); #1;
    total++;
    if (fetch_ok !== 1'b1) begin bad++; $display("[TB] FAIL cen_ok_latency got %b exp 1", fetch_ok); end
    cen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (fetch_ok === 1'b1 && bus_cs === 1'b0) held_ok++;
    end
    fetch_req = 1'b0; cen = 1'b1;
    total++;
    if (held_ok != 3) begin bad++; $display("[TB] FAIL cen_freeze got %0d exp 3", held_ok); end
    @(posedge clk); #1;
    total++;
    if ({fetch_ok, fetch_data} !== {1'b0, 16'h1357}) begin
      bad++;
      $display("[TB] FAIL cen_release got %h exp %h", {fetch_ok, fetch_data}, {1'b0, 16'h1357});
    end
  endtask

  task automatic test_odd_long;
    bit got;
    int d0;
    mem[24'h000100] = 16'h2211; mem[24'h000102] = 16'h4433; mem[24'h000104] = 16'h6655;
    wait_states = 0;
    d0 = dok_cnt;
    build_exp(24'h000101, 4, 1'b0, 32'h0);
    run_data(24'h000101, 3'b100, 1'b1, 1'b0, 32'hFFFF_FFFF, got);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (!got || dok_cnt - d0 != 1) begin bad++; $display("[TB] FAIL odd_long_ok got %0d pulses exp 1", dok_cnt - d0); end
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL odd_long_beats got %0d exp %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL odd_long_beat%0d got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    total++;
    if (data_dout !== exp_rd) begin bad++; $display("[TB] FAIL odd_long_dout got %h exp %h", data_dout, exp_rd); end
  endtask

  task automatic test_odd_word;
    bit got;
    wait_states = 1;
    build_exp(24'h000203, 2, 1'b1, 32'h0000ABCD);
    run_data(24'h000203, 3'b010, 1'b0, 1'b1, 32'h0000ABCD, got);
    total++;
    if (!got) begin bad++; $display("[TB] FAIL odd_word_timeout got 0 exp 1"); end
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL odd_word_beats got %0d exp %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL odd_word_beat%0d got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    wait_states = 0;
  endtask

  task automatic test_wrap;
    bit got;
    int d0;
    mem[24'hFFFFFE] = 16'hA1B2; mem[24'h000000] = 16'hC3D4;
    wait_states = 3;
    stab_err = 0;
    d0 = dok_cnt;
    build_exp(24'hFFFFFE, 4, 1'b0, 32'h0);
    run_data(24'hFFFFFE, 3'b100, 1'b1, 1'b0, 32'h0, got);
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (!got || dok_cnt - d0 != 1) begin bad++; $display("[TB] FAIL wrap_ok got %0d pulses exp 1", dok_cnt - d0); end
    total++;
    if (log_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL wrap_beats got %0d exp %0d", log_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      total++;
      if (log_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL wrap_beat%0d got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    total++;
    if (data_dout !== exp_rd) begin bad++; $display("[TB] FAIL wrap_dout got %h exp %h", data_dout, exp_rd); end
    total++;
    if (stab_err !== 0) begin bad++; $display("[TB] FAIL wrap_stable got %0d exp 0", stab_err); end
    wait_states = 0;
  endtask

  // Reset asserted while the second of three beats is on the bus.
  task automatic test_reset_mid;
    bit got;
    int d0;
    wait_states = 2;
    log_q.delete();
    data_addr = 24'h000345; data_len = 3'b100; data_rd = 1'b1;
    for (int c = 0; c < 100 && !(log_q.size() == 1 && bus_cs === 1'b1); c++) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus_addr !== 24'h000346) begin bad++; $display("[TB] FAIL rst_mid_beat2 got %h exp 000346", bus_addr); end
    d0 = dok_cnt;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_cs, bus_we, bus_addr, bus_dsn, bus_dout, fetch_ok, fetch_data, data_ok, data_dout} !== RST_VAL) begin
      bad++;
      $display("[TB] FAIL rst_mid_values got %h exp %h",
               {bus_cs, bus_we, bus_addr, bus_dsn, bus_dout, fetch_ok, fetch_data, data_ok, data_dout}, RST_VAL);
    end
    data_rd = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    total++;
    if (dok_cnt != d0) begin bad++; $display("[TB] FAIL rst_mid_no_ok got %0d exp %0d", dok_cnt, d0); end
    wait_states = 0;
    run_fetch(24'h000800, got);
    total++;
    if (!got || fetch_data !== mem_rd(24'h000800)) begin
      bad++; $display("[TB] FAIL rst_mid_fetch got %h exp %h", fetch_data, mem_rd(24'h000800));
    end
  endtask

  // Random accesses of every size/alignment interleaved with random fetches.
  task automatic test_random;
    bit got;
    logic [23:0] a, fa;
    logic [2:0] len;
    logic [31:0] din;
    int mode, n;
    logic we;
    for (int it = 0; it < 24; it++) begin
      a = 24'($urandom); len = 3'($urandom_range(0, 7)); din = $urandom;
      mode = $urandom_range(0, 2);
      wait_states = $urandom_range(0, 2);
      n = 1;
      for (int b = 0; b < 3; b++) if (len[b]) n = 1 << b;
      we = (mode == 1);
      build_exp(a, n, we, din);
      run_data(a, len, mode != 1, mode != 0, din, got);
      total++;
      if (!got || log_q.size() != exp_q.size()) begin
        bad++; $display("[TB] FAIL rand%0d_beats got %0d exp %0d", it, log_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        total++;
        if (log_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL rand%0d_beat%0d got %h exp %h", it, i, log_q[i], exp_q[i]); end
      end
      if (!we) begin
        total++;
        if (data_dout !== exp_rd) begin bad++; $display("[TB] FAIL rand%0d_dout got %h exp %h", it, data_dout, exp_rd); end
      end
      fa = 24'($urandom);
      run_fetch(fa, got);
      total++;
      if (!got || log_q.size() != 1 || log_q[0] !== {1'b0, 2'b00, fa[23:1], 1'b0, 16'h0} ||
          fetch_data !== mem_rd({fa[23:1], 1'b0})) begin
        bad++;
        $display("[TB] FAIL rand%0d_fetch got %h exp %h", it, fetch_data, mem_rd({fa[23:1], 1'b0}));
      end
    end
    total++;
    if (viol !== 0) begin bad++; $display("[TB] FAIL rand_overlap got %0d exp 0", viol); end
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence.
  initial begin
    test_reset;
    test_contention;
    test_fetch;
    test_cen;
    test_odd_long;
    test_odd_word;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
